reg_bank_write_arbiter: RTL and testbench
=========================================

Name: reg_bank_write_arbiter

Overview:
Shares the write/clear port of a bank of NUM_REGS N-bit enable/clear registers among NUM_REQ requesters.
- Round-robin arbitration with a req/ack handshake.
- Drives one-hot per-register enables, active-low per-register clears and a shared data bus into the register bank.
- Sits between bus-side masters and the register bank instances.

Parameters:
- N, 8, data width of each register.
- NUM_REGS, 4, registers in the bank.
- ADDR_W, 2, register address width; must satisfy 2**ADDR_W >= NUM_REGS.
- NUM_REQ, 3, number of requesters (2..8).

Ports:
- clk, in, 1, single clock, rising edge.
- reset, in, 1, asynchronous active-high reset.
- req, in, NUM_REQ, per-requester write/clear request.
- req_clr, in, NUM_REQ, 1 = clear-op, 0 = write-op.
- req_lock, in, NUM_REQ, keep grant for the next transaction (see Optional Feature).
- req_addr, in, NUM_REQ*ADDR_W, packed target addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_data, in, NUM_REQ*N, packed write data; requester i at [i*N +: N].
- ack, out, NUM_REQ, one-cycle completion pulse to the granted requester.
- err, out, 1, pulses with ack when the address is >= NUM_REGS.
- busy, out, 1, high while in WRITE.
- reg_en, out, NUM_REGS, one-hot load enable to the register bank.
- reg_n_clr, out, NUM_REGS, active-low clear to the register bank.
- reg_d, out, N, shared write data to the register bank.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; RR pointer = 0.
  - ack = 0, err = 0, busy = 0.
  - reg_en = 0, reg_n_clr = all ones, reg_d = 0.
- Reset asserted mid-WRITE aborts the transaction: no ack, outputs go immediately to reset values.
- FSM has two states:
  - IDLE: if any req is high, pick a winner, latch its id, addr, data and clr into registers, then go to WRITE. Otherwise stay.
  - WRITE: drive the bank from the latched values, pulse ack[winner], advance the pointer, then return to IDLE.
- All bank outputs are registered and active only in WRITE; in IDLE, reg_en = 0 and reg_n_clr = all ones.
- Throughput: one transaction per 2 cycles. Latency: req sampled at edge k, ack and bank strobe high during cycle k+1, registers update at edge k+2.
- Write-op, valid address: reg_en[addr] = 1, reg_d = data, reg_n_clr = all ones.
- Clear-op, valid address: reg_n_clr[addr] = 0, reg_en = 0, reg_d = 0.
- Invalid address (addr >= NUM_REGS): no strobe; ack and err pulse together.
- Round-robin search starts at the pointer and wraps modulo NUM_REQ; the first asserted req wins. After WRITE, pointer = (winner + 1) mod NUM_REQ.
- Handshake rules:
  - Requester holds req, addr, data and clr stable until ack.
  - Payload changes before ack are ignored, because values are latched on entry to WRITE.
  - Requester may keep req high after ack for back-to-back transactions; it then competes again at the next IDLE.
  - Dropping req before grant withdraws the request; dropping it after grant still completes the transaction.
- Simultaneous requests: exactly one ack per WRITE; ack is never asserted in IDLE.

Optional Feature:
- Macro REG_ARB_LOCK_EN.
- Defined: if req_lock[winner] = 1 during WRITE, the pointer is set to the winner instead of advancing, so the same requester wins the next IDLE if it still requests. If it does not request, normal round-robin applies from the winner's index.
- Undefined: req_lock is ignored (left unconnected internally) and the pointer always advances.

Decomposition:
- Shared package (reg_bank_pkg):
  - state encoding constants ST_IDLE = 1'b0, ST_WRITE = 1'b1.
  - default N, NUM_REGS and ADDR_W values.
- One sub-module, rr_select: combinational NUM_REQ-wide round-robin picker.
  - Inputs: req, pointer.
  - Outputs: grant_valid, grant_idx.
  - Reused by future bus arbiters.

Test Plan:
1. Reset mid-WRITE: req[0] = 1, assert reset during cycle k+1 → ack = 0, reg_en = 0, reg_n_clr = 4'b1111; pointer resets to 0.
2. Single write: req[1] = 1, addr = 2, data = 8'hA5 → one cycle later reg_en = 4'b0100, reg_d = 8'hA5, ack = 3'b010, err = 0; the register-bank model then holds 8'hA5.
3. Clear: register 3 preloaded with 8'h3C; req[2] = 1, clr = 1, addr = 3 → reg_n_clr = 4'b0111, reg_en = 0, ack[2] pulses; register 3 reads 8'h00.
4. Contention: req = 3'b111 held continuously → ack order is 0, 1, 2, 0, with one ack every 2 cycles and never two acks in one cycle.
5. Invalid address: NUM_REGS = 3, addr = 3 → ack and err pulse, reg_en = 0, reg_n_clr = all ones.
6. Lock (REG_ARB_LOCK_EN defined): req = 3'b011, req_lock[0] = 1 → requester 0 wins 3 consecutive times. Drop lock → next grant goes to 1. With the macro undefined, grants alternate 0, 1.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// ----------------------------------------------------------------------------
// reg_bank_pkg
// Shared definitions for the register-bank write arbiter and its helpers.
//   state_t          : arbiter FSM encoding (ST_IDLE / ST_WRITE)
//   DEF_*            : default geometry of the register bank and requester count
//   rr_next()        : modulo increment used for round-robin pointer advance
// ----------------------------------------------------------------------------
package reg_bank_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    localparam int DEF_N        = 8;
    localparam int DEF_NUM_REGS = 4;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_NUM_REQ  = 3;

    // Next index after idx in a ring of num_req entries.
    function automatic int rr_next(input int idx, input int num_req);
        return (idx + 1 >= num_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/reg_bank_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// reg_bank_write_arbiter_if
// Bundles the requester handshake and the register-bank strobes.
//   req/req_clr/req_lock : per-requester request, clear-op select, grant lock
//   req_addr/req_data    : packed per-requester payload (slot i at [i*W +: W])
//   ack/err/busy         : completion pulse, invalid-address flag, WRITE flag
//   reg_en/reg_n_clr/reg_d : one-hot load, active-low clear, shared data
// Modports: master (requesters), slave (arbiter), bank (register bank).
// ----------------------------------------------------------------------------
interface reg_bank_write_arbiter_if
    import reg_bank_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REQ  = DEF_NUM_REQ
);

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_clr;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*N-1:0]      req_data;

    logic [NUM_REQ-1:0]        ack;
    logic                      err;
    logic                      busy;

    logic [NUM_REGS-1:0]       reg_en;
    logic [NUM_REGS-1:0]       reg_n_clr;
    logic [N-1:0]              reg_d;

    modport master (
        output req, req_clr, req_lock, req_addr, req_data,
        input  ack, err, busy
    );

    modport slave (
        input  req, req_clr, req_lock, req_addr, req_data,
        output ack, err, busy, reg_en, reg_n_clr, reg_d
    );

    modport bank (
        input reg_en, reg_n_clr, reg_d
    );

endinterface

// File: rtl/reg_bank_write_arbiter_rr_select.sv
// ----------------------------------------------------------------------------
// rr_select
// Combinational round-robin picker: scans req starting at ptr, wrapping modulo
// NUM_REQ, and returns the first asserted index.
//   req         : request vector
//   ptr         : index with highest priority this cycle
//   grant_valid : at least one request is asserted
//   grant_idx   : winning index (0 when grant_valid is low)
// ----------------------------------------------------------------------------
module rr_select #(
    parameter int NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic                       grant_valid,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!grant_valid && req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/reg_bank_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_bank_write_arbiter
// Shares the write/clear port of a register bank among NUM_REQ requesters
// with round-robin arbitration. Two-state FSM: IDLE picks and latches a
// winner, WRITE drives the bank from the latched values and pulses ack.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : reg_bank_write_arbiter_if.slave (requests in, ack/err/busy and
//           bank strobes reg_en / reg_n_clr / reg_d out)
// Build option: define REG_ARB_LOCK_EN to let req_lock of the winner hold the
// round-robin pointer on itself; otherwise req_lock is ignored.
// ----------------------------------------------------------------------------
module reg_bank_write_arbiter
    import reg_bank_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REQ  = DEF_NUM_REQ
) (
    input  logic                     clk,
    input  logic                     reset,
    reg_bank_write_arbiter_if.slave  bus
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t            state;
    state_t            next_state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [N-1:0]      win_data;
    logic              win_clr;
    logic              grant_valid;
    logic [PTR_W-1:0]  grant_idx;
    logic              lock_hold;
    logic              addr_ok;
    logic [PTR_W-1:0]  ptr_adv;

    logic [ADDR_W-1:0] addr_arr [NUM_REQ];
    logic [N-1:0]      data_arr [NUM_REQ];

    // Unpack the per-requester payload so the winner can be selected by index.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign data_arr[g] = bus.req_data[g*N +: N];
    end

    rr_select #(
        .NUM_REQ(NUM_REQ)
    ) u_rr_select (
        .req         (bus.req),
        .ptr         (rr_ptr),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

`ifdef REG_ARB_LOCK_EN
    assign lock_hold = bus.req_lock[win_idx];
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
    assign lock_hold   = 1'b0;
`endif

    assign ptr_adv = PTR_W'(rr_next(int'(win_idx), NUM_REQ));
    assign addr_ok = (int'(win_addr) < NUM_REGS);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (grant_valid) next_state = ST_WRITE;
            ST_WRITE: next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Payload is captured on entry to WRITE so later requester changes are ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_idx  <= '0;
            win_addr <= '0;
            win_data <= '0;
            win_clr  <= 1'b0;
        end else if (state == ST_IDLE && grant_valid) begin
            win_idx  <= grant_idx;
            win_addr <= addr_arr[grant_idx];
            win_data <= data_arr[grant_idx];
            win_clr  <= bus.req_clr[grant_idx];
        end
    end

    // Pointer moves only when a WRITE completes; a reset mid-WRITE leaves it at 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (state == ST_WRITE) begin
            rr_ptr <= lock_hold ? win_idx : ptr_adv;
        end
    end

    // Outputs decode from state and latched registers only, never from inputs.
    always_comb begin
        bus.ack       = '0;
        bus.err       = 1'b0;
        bus.busy      = 1'b0;
        bus.reg_en    = '0;
        bus.reg_n_clr = '1;
        bus.reg_d     = '0;
        if (state == ST_WRITE) begin
            bus.busy = 1'b1;
            bus.ack  = NUM_REQ'(1) << win_idx;
            bus.err  = !addr_ok;
            if (addr_ok) begin
                if (win_clr) begin
                    bus.reg_n_clr = ~(NUM_REGS'(1) << win_addr);
                end else begin
                    bus.reg_en = NUM_REGS'(1) << win_addr;
                    bus.reg_d  = win_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_bank_write_arbiter
// Self-checking bench for reg_bank_write_arbiter. Instance A uses the default
// 4-register bank with a behavioural register-bank model; instance B has
// NUM_REGS = 3 so that address 3 is out of range. Honours REG_ARB_LOCK_EN.
// ----------------------------------------------------------------------------
module tb_reg_bank_write_arbiter;

    localparam int N          = 8;
    localparam int ADDR_W     = 2;
    localparam int NUM_REQ    = 3;
    localparam int NUM_REGS_A = 4;
    localparam int NUM_REGS_B = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] bank_a [NUM_REGS_A];

    reg_bank_write_arbiter_if #(.N(N), .NUM_REGS(NUM_REGS_A), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ)) bus_a ();
    reg_bank_write_arbiter_if #(.N(N), .NUM_REGS(NUM_REGS_B), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ)) bus_b ();

    reg_bank_write_arbiter #(.N(N), .NUM_REGS(NUM_REGS_A), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    reg_bank_write_arbiter #(.N(N), .NUM_REGS(NUM_REGS_B), .ADDR_W(ADDR_W), .NUM_REQ(NUM_REQ)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clk = ~clk;

    // Register bank model behind instance A: clear wins over load.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS_A; r++) bank_a[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS_A; r++) begin
                if (!bus_a.reg_n_clr[r]) bank_a[r] <= '0;
                else if (bus_a.reg_en[r]) bank_a[r] <= bus_a.reg_d;
            end
        end
    end

    task automatic clear_inputs();
        bus_a.req = '0; bus_a.req_clr = '0; bus_a.req_lock = '0; bus_a.req_addr = '0; bus_a.req_data = '0;
        bus_b.req = '0; bus_b.req_clr = '0; bus_b.req_lock = '0; bus_b.req_addr = '0; bus_b.req_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_req_a(input int i, input bit clr, input int addr, input int data);
        bus_a.req[i]                     = 1'b1;
        bus_a.req_clr[i]                 = clr;
        bus_a.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        bus_a.req_data[i*N +: N]         = N'(data);
    endtask

    task automatic drive_req_b(input int i, input bit clr, input int addr, input int data);
        bus_b.req[i]                     = 1'b1;
        bus_b.req_clr[i]                 = clr;
        bus_b.req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(addr);
        bus_b.req_data[i*N +: N]         = N'(data);
    endtask

    task automatic test_reset();
        @(negedge clk);
        clear_inputs();
        reset = 1'b1;
        #1;
        checks++; if (bus_a.ack !== 3'b000) begin failures++; $display("[TB] FAIL reset_ack got=%b exp=000", bus_a.ack); end
        checks++; if (bus_a.err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%b exp=0", bus_a.err); end
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", bus_a.busy); end
        checks++; if (bus_a.reg_en !== 4'b0000) begin failures++; $display("[TB] FAIL reset_reg_en got=%b exp=0000", bus_a.reg_en); end
        checks++; if (bus_a.reg_n_clr !== 4'b1111) begin failures++; $display("[TB] FAIL reset_reg_n_clr got=%b exp=1111", bus_a.reg_n_clr); end
        checks++; if (bus_a.reg_d !== 8'h00) begin failures++; $display("[TB] FAIL reset_reg_d got=%h exp=00", bus_a.reg_d); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive_req_a(1, 1'b0, 0, 8'h11);
        @(negedge clk);
        bus_a.req = '0;
        @(negedge clk);
        drive_req_a(0, 1'b0, 1, 8'h55);
        @(negedge clk);
        checks++; if (bus_a.ack !== 3'b001) begin failures++; $display("[TB] FAIL midrst_pre_ack got=%b exp=001", bus_a.ack); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus_a.ack !== 3'b000) begin failures++; $display("[TB] FAIL midrst_ack got=%b exp=000", bus_a.ack); end
        checks++; if (bus_a.busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy got=%b exp=0", bus_a.busy); end
        checks++; if (bus_a.reg_en !== 4'b0000) begin failures++; $display("[TB] FAIL midrst_reg_en got=%b exp=0000", bus_a.reg_en); end
        checks++; if (bus_a.reg_n_clr !== 4'b1111) begin failures++; $display("[TB] FAIL midrst_reg_n_clr got=%b exp=1111", bus_a.reg_n_clr); end
        @(negedge clk);
        reset = 1'b0;
        drive_req_a(1, 1'b0, 2, 8'h22);
        drive_req_a(2, 1'b0, 3, 8'h33);
        @(negedge clk);
        checks++; if (bus_a.ack !== 3'b001) begin failures++; $display("[TB] FAIL midrst_ptr_ack got=%b exp=001", bus_a.ack); end
        bus_a.req = '0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        do_reset();
        drive_req_a(1, 1'b0, 2, 8'hA5);
        @(negedge clk);
        bus_a.req = '0;
        checks++; if (bus_a.reg_en !== 4'b0100) begin failures++; $display("[TB] FAIL write_reg_en got=%b exp=0100", bus_a.reg_en); end
        checks++; if (bus_a.reg_d !== 8'hA5) begin failures++; $display("[TB] FAIL write_reg_d got=%h exp=a5", bus_a.reg_d); end
        checks++; if (bus_a.ack !== 3'b010) begin failures++; $display("[TB] FAIL write_ack got=%b exp=010", bus_a.ack); end
        checks++; if (bus_a.err !== 1'b0) begin failures++; $display("[TB] FAIL write_err got=%b exp=0", bus_a.err); end
        checks++; if (bus_a.busy !== 1'b1) begin failures++; $display("[TB] FAIL write_busy got=%b exp=1", bus_a.busy); end
        checks++; if (bus_a.reg_n_clr !== 4'b1111) begin failures++; $display("[TB] FAIL write_reg_n_clr got=%b exp=1111", bus_a.reg_n_clr); end
        @(negedge clk);
        checks++; if (bus_a.ack !== 3'b000) begin failures++; $display("[TB] FAIL write_idle_ack got=%b exp=000", bus_a.ack); end
        checks++; if (bus_a.reg_en !== 4'b0000) begin failures++; $display("[TB] FAIL write_idle_reg_en got=%b exp=0000", bus_a.reg_en); end
        checks++; if (bank_a[2] !== 8'hA5) begin failures++; $display("[TB] FAIL write_bank got=%h exp=a5", bank_a[2]); end
    endtask

    task automatic test_clear();
        do_reset();
        drive_req_a(0, 1'b0, 3, 8'h3C);
        @(negedge clk);
        bus_a.req = '0;
        @(negedge clk);
        checks++; if (bank_a[3] !== 8'h3C) begin failures++; $display("[TB] FAIL clear_preload got=%h exp=3c", bank_a[3]); end
        drive_req_a(2, 1'b1, 3, 8'hFF);
        @(negedge clk);
        bus_a.req = '0;
        checks++; if (bus_a.reg_n_clr !== 4'b0111) begin failures++; $display("[TB] FAIL clear_reg_n_clr got=%b exp=0111", bus_a.reg_n_clr); end
        checks++; if (bus_a.reg_en !== 4'b0000) begin failures++; $display("[TB] FAIL clear_reg_en got=%b exp=0000", bus_a.reg_en); end
        checks++; if (bus_a.reg_d !== 8'h00) begin failures++; $display("[TB] FAIL clear_reg_d got=%h exp=00", bus_a.reg_d); end
        checks++; if (bus_a.ack !== 3'b100) begin failures++; $display("[TB] FAIL clear_ack got=%b exp=100", bus_a.ack); end
        @(negedge clk);
        checks++; if (bank_a[3] !== 8'h00) begin failures++; $display("[TB] FAIL clear_bank got=%h exp=00", bank_a[3]); end
        checks++; if (bus_a.reg_n_clr !== 4'b1111) begin failures++; $display("[TB] FAIL clear_idle_reg_n_clr got=%b exp=1111", bus_a.reg_n_clr); end
    endtask

    task automatic test_contention();
        logic [2:0] exp_ack;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) drive_req_a(i, 1'b0, i, 8'h10 + i);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_ack = (c % 2 == 0) ? 3'(1 << ((c / 2) % NUM_REQ)) : 3'b000;
            checks++;
            if (bus_a.ack !== exp_ack) begin
                failures++;
                $display("[TB] FAIL contention_ack cycle=%0d got=%b exp=%b", c, bus_a.ack, exp_ack);
            end
        end
        bus_a.req = '0;
        @(negedge clk);
    endtask

    task automatic test_invalid_addr();
        do_reset();
        drive_req_b(1, 1'b0, 3, 8'h77);
        @(negedge clk);
        bus_b.req = '0;
        checks++; if (bus_b.ack !== 3'b010) begin failures++; $display("[TB] FAIL inval_ack got=%b exp=010", bus_b.ack); end
        checks++; if (bus_b.err !== 1'b1) begin failures++; $display("[TB] FAIL inval_err got=%b exp=1", bus_b.err); end
        checks++; if (bus_b.reg_en !== 3'b000) begin failures++; $display("[TB] FAIL inval_reg_en got=%b exp=000", bus_b.reg_en); end
        checks++; if (bus_b.reg_n_clr !== 3'b111) begin failures++; $display("[TB] FAIL inval_reg_n_clr got=%b exp=111", bus_b.reg_n_clr); end
        @(negedge clk);
        checks++; if (bus_b.err !== 1'b0) begin failures++; $display("[TB] FAIL inval_idle_err got=%b exp=0", bus_b.err); end
        drive_req_b(0, 1'b0, 2, 8'h5A);
        @(negedge clk);
        bus_b.req = '0;
        checks++; if (bus_b.err !== 1'b0) begin failures++; $display("[TB] FAIL top_addr_err got=%b exp=0", bus_b.err); end
        checks++; if (bus_b.reg_en !== 3'b100) begin failures++; $display("[TB] FAIL top_addr_reg_en got=%b exp=100", bus_b.reg_en); end
        checks++; if (bus_b.reg_d !== 8'h5A) begin failures++; $display("[TB] FAIL top_addr_reg_d got=%h exp=5a", bus_b.reg_d); end
        @(negedge clk);
    endtask

    task automatic test_lock();
        int         exp_order [4];
        logic [2:0] exp_ack;
`ifdef REG_ARB_LOCK_EN
        exp_order = '{0, 0, 0, 1};
`else
        exp_order = '{0, 1, 0, 1};
`endif
        do_reset();
        drive_req_a(0, 1'b0, 0, 8'h01);
        drive_req_a(1, 1'b0, 1, 8'h02);
        bus_a.req_lock = 3'b001;
        for (int g = 0; g < 4; g++) begin
            @(negedge clk);
            exp_ack = 3'(1 << exp_order[g]);
            checks++;
            if (bus_a.ack !== exp_ack) begin
                failures++;
                $display("[TB] FAIL lock_grant n=%0d got=%b exp=%b", g, bus_a.ack, exp_ack);
            end
            if (g == 2) bus_a.req_lock = '0;
            @(negedge clk);
            checks++;
            if (bus_a.ack !== 3'b000) begin
                failures++;
                $display("[TB] FAIL lock_idle_ack n=%0d got=%b exp=000", g, bus_a.ack);
            end
        end
        bus_a.req = '0;
        @(negedge clk);
    endtask

    // Transaction-level reference: pending grant, pointer and latched payload.
    task automatic test_random();
        int         m_ptr, m_idx, m_addr, m_data, j, lk;
        bit         m_busy, m_clr, found, valid;
        logic [2:0] e_ack, e_en, e_nclr;
        logic       e_err, e_busy;
        do_reset();
        m_ptr  = 0;
        m_busy = 1'b0;
        m_idx  = 0; m_addr = 0; m_data = 0; m_clr = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus_b.req      = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            bus_b.req_clr  = 3'($urandom_range(0, 7));
            bus_b.req_lock = 3'($urandom_range(0, 7));
            bus_b.req_addr = 6'($urandom_range(0, 63));
            bus_b.req_data = 24'($urandom);
            if (!m_busy) begin
                found = 1'b0;
                for (int k = 0; k < NUM_REQ; k++) begin
                    j = (m_ptr + k) % NUM_REQ;
                    if (!found && bus_b.req[j]) begin
                        found  = 1'b1;
                        m_idx  = j;
                        m_addr = int'(bus_b.req_addr[j*ADDR_W +: ADDR_W]);
                        m_data = int'(bus_b.req_data[j*N +: N]);
                        m_clr  = bus_b.req_clr[j];
                    end
                end
                m_busy = found;
            end else begin
                lk = 0;
`ifdef REG_ARB_LOCK_EN
                lk = int'(bus_b.req_lock[m_idx]);
`endif
                m_ptr  = (lk != 0) ? m_idx : (m_idx + 1) % NUM_REQ;
                m_busy = 1'b0;
            end
            @(negedge clk);
            valid  = m_busy && (m_addr < NUM_REGS_B);
            e_busy = m_busy;
            e_ack  = m_busy ? 3'(1 << m_idx) : 3'b000;
            e_err  = m_busy && !valid;
            e_en   = (valid && !m_clr) ? 3'(1 << m_addr) : 3'b000;
            e_nclr = (valid && m_clr) ? ~3'(1 << m_addr) : 3'b111;
            checks++; if (bus_b.ack !== e_ack) begin failures++; $display("[TB] FAIL rand_ack cycle=%0d got=%b exp=%b", c, bus_b.ack, e_ack); end
            checks++; if (bus_b.err !== e_err) begin failures++; $display("[TB] FAIL rand_err cycle=%0d got=%b exp=%b", c, bus_b.err, e_err); end
            checks++; if (bus_b.busy !== e_busy) begin failures++; $display("[TB] FAIL rand_busy cycle=%0d got=%b exp=%b", c, bus_b.busy, e_busy); end
            checks++; if (bus_b.reg_en !== e_en) begin failures++; $display("[TB] FAIL rand_reg_en cycle=%0d got=%b exp=%b", c, bus_b.reg_en, e_en); end
            checks++; if (bus_b.reg_n_clr !== e_nclr) begin failures++; $display("[TB] FAIL rand_reg_n_clr cycle=%0d got=%b exp=%b", c, bus_b.reg_n_clr, e_nclr); end
            if (valid && !m_clr) begin
                checks++;
                if (bus_b.reg_d !== N'(m_data)) begin
                    failures++;
                    $display("[TB] FAIL rand_reg_d cycle=%0d got=%h exp=%h", c, bus_b.reg_d, N'(m_data));
                end
            end
        end
        bus_b.req = '0;
        @(negedge clk);
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_reset_mid_write();
        test_single_write();
        test_clear();
        test_contention();
        test_invalid_addr();
        test_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
